// File: rtl/gpio_cmd_pkg.sv
// gpio_cmd_pkg: shared states, ASCII constants and hex decoding for the GPIO command receiver.
package gpio_cmd_pkg;

    typedef enum logic [2:0] {
        S_MATCH,
        S_DIGITS,
        S_CR_WAIT,
        S_LF_WAIT,
        S_DROP,
        S_COMMIT
    } gpio_rx_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Returns {is_hex, nibble}; letters map via their low nibble (A/a = x1) plus 9.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
        if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) return {1'b1, b[3:0] + 4'd9};
        return 5'd0;
    endfunction

endpackage

// File: rtl/axis_gpio_cmd_rx.sv
// axis_gpio_cmd_rx: parses "LEDS: 0x<hex>\r\n" AXI-Stream packets into a registered GPIO bank.
// Define GPIO_RX_ERR_COUNT_EN to add the saturating err_count output.
module axis_gpio_cmd_rx
    import gpio_cmd_pkg::*;
#(
    parameter int                        PREFIX_CHARS  = 8,
    parameter logic [8*PREFIX_CHARS-1:0] PREFIX_STRING = "LEDS: 0x",
    parameter int                        GPIO_WIDTH    = 2,
    parameter logic [GPIO_WIDTH-1:0]     GPIO_RESET    = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            s_axis_data,
    input  logic                  s_axis_valid,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  cmd_valid,
    output logic                  cmd_error
`ifdef GPIO_RX_ERR_COUNT_EN
    ,
    output logic [15:0]           err_count
`endif
);

    localparam int DIGITS = (GPIO_WIDTH + 3) / 4;
    localparam int IW = PREFIX_CHARS > 1 ? $clog2(PREFIX_CHARS) : 1;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int AW = 4 * DIGITS;
    localparam logic [IW-1:0] LAST_IDX = IW'(PREFIX_CHARS - 1);
    localparam logic [CW-1:0] DIGIT_MAX = CW'(DIGITS);

    gpio_rx_state_e  state, nxt;
    logic [IW-1:0]   idx, nxt_idx;
    logic [AW-1:0]   acc, nxt_acc;
    logic [CW-1:0]   cnt, nxt_cnt;
    logic            err, hs;
    logic [4:0]      hx;
    logic [7:0]      prefix [PREFIX_CHARS];

    for (genvar i = 0; i < PREFIX_CHARS; i++) begin : g_prefix
        assign prefix[i] = PREFIX_STRING[8*(PREFIX_CHARS-i)-1 -: 8];
    end

    assign s_axis_ready = reset_n && state != S_COMMIT;
    assign hs = s_axis_valid && s_axis_ready;
    assign hx = hex_decode(s_axis_data);

    always_comb begin
        nxt = state;
        nxt_idx = idx;
        nxt_acc = acc;
        nxt_cnt = cnt;
        err = 1'b0;
        if (hs) begin
            case (state)
                S_MATCH: begin
                    if (s_axis_data != prefix[idx] || s_axis_last) err = 1'b1;
                    else if (idx == LAST_IDX) nxt = S_DIGITS;
                    else nxt_idx = idx + 1'b1;
                end
                S_DIGITS: begin
                    if (hx[4] && cnt != DIGIT_MAX && !s_axis_last) begin
                        nxt_acc = (acc << 4) | AW'(hx[3:0]);
                        nxt_cnt = cnt + 1'b1;
                    end else if (s_axis_data == ASCII_CR && cnt != '0 && !s_axis_last) nxt = S_LF_WAIT;
                    else err = 1'b1;
                end
                S_CR_WAIT: if (s_axis_data == ASCII_CR && !s_axis_last) nxt = S_LF_WAIT; else err = 1'b1;
                // The range check rides on the LF so an oversized value never reaches COMMIT.
                S_LF_WAIT: if (s_axis_data == ASCII_LF && s_axis_last && (acc >> GPIO_WIDTH) == '0) nxt = S_COMMIT; else err = 1'b1;
                S_DROP: if (s_axis_last) nxt = S_MATCH;
                default: ;
            endcase
            if (err) nxt = s_axis_last ? S_MATCH : S_DROP;
        end
        if (state == S_COMMIT) nxt = S_MATCH;
        if (err || (nxt == S_MATCH && state != S_MATCH)) begin
            nxt_idx = '0;
            nxt_acc = '0;
            nxt_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_MATCH;
            idx <= '0;
            acc <= '0;
            cnt <= '0;
            gpio_out <= GPIO_RESET;
            cmd_valid <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            state <= nxt;
            idx <= nxt_idx;
            acc <= nxt_acc;
            cnt <= nxt_cnt;
            cmd_valid <= state == S_COMMIT;
            cmd_error <= err;
            if (state == S_COMMIT) gpio_out <= acc[GPIO_WIDTH-1:0];
        end
    end

`ifdef GPIO_RX_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) err_count <= '0;
        else if (err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axis_gpio_cmd_rx.sv
// tb_axis_gpio_cmd_rx: directed and randomized packets scored against a whole-packet reference model.
module tb_axis_gpio_cmd_rx;

    localparam int GW = 2;
    localparam int DIG = (GW + 3) / 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_last = 1'b0;
    logic          s_axis_ready;
    logic [GW-1:0] gpio_out;
    logic          cmd_valid;
    logic          cmd_error;
`ifdef GPIO_RX_ERR_COUNT_EN
    logic [15:0]   err_count;
`endif

    int vectors = 0, miscompares = 0;
    int nval = 0, nerr = 0, stalls = 0;
    int model_gpio = 0, model_errs = 0;
    logic [7:0] pkt [$];
    string pfx = "LEDS: 0x";

    axis_gpio_cmd_rx #(.GPIO_WIDTH(GW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_axis_data(s_axis_data),
        .s_axis_valid(s_axis_valid),
        .s_axis_last(s_axis_last),
        .s_axis_ready(s_axis_ready),
        .gpio_out(gpio_out),
        .cmd_valid(cmd_valid),
        .cmd_error(cmd_error)
`ifdef GPIO_RX_ERR_COUNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) nval++;
        if (cmd_error) nerr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A packet is accepted iff it is exactly prefix, 1..DIG hex digits, CR, LF and the value fits.
    function automatic bit model_pkt(input logic [7:0] q [$], output int v);
        int n = q.size();
        int nd = n - pfx.len() - 2;
        v = 0;
        if (nd < 1 || nd > DIG) return 0;
        for (int i = 0; i < pfx.len(); i++) if (q[i] != pfx[i]) return 0;
        for (int i = 0; i < nd; i++) begin
            int c = q[pfx.len()+i];
            if (c >= "0" && c <= "9") v = v * 16 + c - "0";
            else if (c >= "a" && c <= "f") v = v * 16 + c - "a" + 10;
            else if (c >= "A" && c <= "F") v = v * 16 + c - "A" + 10;
            else return 0;
        end
        if (q[n-2] != 8'h0D || q[n-1] != 8'h0A) return 0;
        return v < (1 << GW);
    endfunction

    function automatic logic [7:0] hexc(input int n, input bit up);
        return n < 10 ? 8'(48 + n) : 8'((up ? 65 : 97) + n - 10);
    endfunction

    task automatic load(input string s, input bit cr, input bit lf);
        pkt.delete();
        for (int i = 0; i < s.len(); i++) pkt.push_back(s[i]);
        if (cr) pkt.push_back(8'h0D);
        if (lf) pkt.push_back(8'h0A);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        bit done = 0;
        s_axis_data = d;
        s_axis_last = l;
        s_axis_valid = 1'b1;
        for (int t = 0; t < 16 && !done; t++) begin
            done = s_axis_ready;
            if (!done) stalls++;
            @(negedge clk);
        end
        s_axis_valid = 1'b0;
        if (!done) check("hs_timeout", 0, 1);
    endtask

    task automatic settle(input bit ok, input int v0, input int e0, input int s0);
        repeat (2) @(negedge clk);
        check("valid_cnt", nval - v0, ok);
        check("err_cnt", nerr - e0, !ok);
        check("stalls", stalls - s0, 0);
        check("gpio", gpio_out, model_gpio);
`ifdef GPIO_RX_ERR_COUNT_EN
        check("err_count", err_count, model_errs);
`endif
    endtask

    task automatic send_pkt(input bit gaps);
        int v0 = nval, e0 = nerr, s0 = stalls, val;
        bit ok = model_pkt(pkt, val);
        foreach (pkt[i]) begin
            send_byte(pkt[i], i == pkt.size() - 1);
            if (gaps && i != pkt.size() - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if (ok) begin
            check("commit_ready", s_axis_ready, 0);
            check("early_valid", cmd_valid, 0);
            @(negedge clk);
            check("valid_pulse", cmd_valid, 1);
            check("gpio_new", gpio_out, val);
            model_gpio = val;
        end else begin
            @(negedge clk);
            model_errs++;
        end
        settle(ok, v0, e0, s0);
    endtask

    initial begin
        int v0, e0, s0;
        repeat (3) @(negedge clk);
        check("rst_gpio", gpio_out, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_error", cmd_error, 0);
        check("rst_ready", s_axis_ready, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_up", s_axis_ready, 1);

        load("LEDS: 0x3", 1, 1); send_pkt(0);
        load("LEDS: 0xa", 1, 1); send_pkt(0);

        load("LEDX: 0x1", 1, 1);
        v0 = nval; e0 = nerr; s0 = stalls;
        for (int i = 0; i < 4; i++) send_byte(pkt[i], 0);
        check("mismatch_err", cmd_error, 1);
        for (int i = 4; i < pkt.size(); i++) send_byte(pkt[i], i == pkt.size() - 1);
        @(negedge clk);
        model_errs++;
        settle(0, v0, e0, s0);
        load("LEDS: 0x1", 1, 1); send_pkt(0);

        load("LEDS: 0x", 1, 1); send_pkt(0);
        load("LEDS: 0x12", 1, 1); send_pkt(1);
        load("LEDS: 0x2", 1, 0); send_pkt(1);

        load("LEDS: 0", 0, 0);
        foreach (pkt[i]) send_byte(pkt[i], 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_gpio", gpio_out, 0);
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_ready", s_axis_ready, 0);
        model_gpio = 0;
        model_errs = 0;
`ifdef GPIO_RX_ERR_COUNT_EN
        check("mid_rst_errcnt", err_count, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        load("LEDS: 0x2", 1, 1); send_pkt(0);

        for (int k = 0; k < 150; k++) begin
            int nd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 1;
            load("LEDS: 0x", 0, 0);
            for (int d = 0; d < nd; d++)
                pkt.push_back(hexc($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3), 1'($urandom)));
            pkt.push_back(8'h0D);
            pkt.push_back(8'h0A);
            case ($urandom_range(0, 5))
                0: pkt[$urandom_range(0, pkt.size() - 1)] = 8'($urandom);
                1: while (pkt.size() > 1 && $urandom_range(0, 2) != 0) void'(pkt.pop_back());
                default: ;
            endcase
            send_pkt(1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
